// File: rtl/param_sorter.sv
// Batch sorter: loads DEPTH unsigned elements, then emits them one per transfer in
// ascending or descending order, resolving ties by load order.
module param_sorter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             descend,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [0:0] {StLoad, StEmit} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   load_cnt_q, load_cnt_d;
  logic [CntW-1:0]   emit_cnt_q, emit_cnt_d;
  logic [DEPTH-1:0]  taken_q, taken_d;
  logic              order_q, order_d;
  logic              load_en;
  logic [WIDTH-1:0]  buffer_q [DEPTH];

  logic [IdxW-1:0]   sel_idx;
  logic [WIDTH-1:0]  sel_val;
  logic              sel_found;

  // Strict compare keeps the earliest index on ties, so equal values leave in load order.
  always_comb begin
    sel_idx   = '0;
    sel_val   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!taken_q[i]) begin
        if (!sel_found ||
            (order_q ? (buffer_q[i] > sel_val) : (buffer_q[i] < sel_val))) begin
          sel_found = 1'b1;
          sel_idx   = IdxW'(i);
          sel_val   = buffer_q[i];
        end
      end
    end
  end

  // Outputs derive from state so reset takes effect without a clock edge.
  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StEmit);
    out_data  = out_valid ? sel_val : '0;
    out_last  = out_valid && (emit_cnt_q == CntW'(DEPTH - 1));
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    emit_cnt_d = emit_cnt_q;
    taken_d    = taken_q;
    order_d    = order_q;
    load_en    = 1'b0;
    if (abort) begin
      state_d    = StLoad;
      load_cnt_d = '0;
      emit_cnt_d = '0;
      taken_d    = '0;
      order_d    = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_valid) begin
            load_en    = 1'b1;
            load_cnt_d = load_cnt_q + CntW'(1);
            if (load_cnt_q == '0) begin
              order_d = descend;
            end
            if (load_cnt_q == CntW'(DEPTH - 1)) begin
              state_d = StEmit;
            end
          end
        end
        StEmit: begin
          if (out_ready) begin
            if (out_last) begin
              state_d    = StLoad;
              load_cnt_d = '0;
              emit_cnt_d = '0;
              taken_d    = '0;
            end else begin
              taken_d[sel_idx] = 1'b1;
              emit_cnt_d       = emit_cnt_q + CntW'(1);
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StLoad;
      load_cnt_q <= '0;
      emit_cnt_q <= '0;
      taken_q    <= '0;
      order_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      taken_q    <= taken_d;
      order_q    <= order_d;
    end
  end

  // Storage needs no reset: every slot is rewritten before a batch can emit.
  always_ff @(posedge clk) begin
    if (load_en) begin
      buffer_q[load_cnt_q[IdxW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_param_sorter.sv
// Self-checking bench for param_sorter (WIDTH=8, DEPTH=4): table of batches feeding a
// scoreboard queue, plus hand-written stall, abort and reset sequences.
module tb_param_sorter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       descend;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  param_sorter #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .descend   (descend),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] din;
    logic            desc;
    logic [3:0][7:0] exp;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  vec_t tbl [6];
  exp_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic [7:0] a, b, c, d, input logic desc,
                              input logic [7:0] e0, e1, e2, e3);
    vec_t v;
    v.din  = {d, c, b, a};
    v.desc = desc;
    v.exp  = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every real output transfer against the queue head.
  always @(negedge clk) begin
    if (!reset && !abort && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e.data});
        check("out_last", {31'd0, out_last}, {31'd0, e.last});
      end
    end
  end

  // Later elements drive the opposite descend value, which must be ignored.
  task automatic drive_batch(input int b);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.data = tbl[b].exp[k];
      e.last = (k == 3);
      sb_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = tbl[b].din[k];
      descend  = (k == 0) ? tbl[b].desc : ~tbl[b].desc;
      if (k == 3) begin
        @(negedge clk);
        check("out_valid_before_last_accept", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    descend  = 1'b0;
    check("out_valid_after_last_accept", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain(input int exp_cycles);
    int cycles = 0;
    while (sb_q.size() != 0 && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
    if (exp_cycles > 0) check("emit_cycles", cycles, exp_cycles);
    check("in_ready_after_batch", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(8'd5,   8'd3,   8'd9,   8'd1,   1'b0, 8'd1,   8'd3,   8'd5,   8'd9);
    tbl[1] = mk(8'd5,   8'd3,   8'd9,   8'd1,   1'b1, 8'd9,   8'd5,   8'd3,   8'd1);
    tbl[2] = mk(8'd7,   8'd2,   8'd7,   8'd2,   1'b0, 8'd2,   8'd2,   8'd7,   8'd7);
    tbl[3] = mk(8'hFF,  8'h00,  8'h80,  8'h01,  1'b0, 8'h00,  8'h01,  8'h80,  8'hFF);
    tbl[4] = mk(8'hFF,  8'h00,  8'h7F,  8'hFF,  1'b1, 8'hFF,  8'hFF,  8'h7F,  8'h00);
    tbl[5] = mk(8'd4,   8'd8,   8'd6,   8'd2,   1'b0, 8'd2,   8'd4,   8'd6,   8'd8);

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    descend   = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_last",  {31'd0, out_last},  32'd0);
    check("reset_out_data",  {24'd0, out_data},  32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Plain batches: ascending, descending, duplicates, extremes.
    for (int b = 0; b < 5; b++) begin
      drive_batch(b);
      drain(4);
    end

    // Stall three cycles on the first emitted element.
    out_ready = 1'b0;
    drive_batch(0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_data",  {24'd0, out_data},  32'd1);
      check("stall_out_last",  {31'd0, out_last},  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain(4);

    // Abort after two accepts; the simultaneous accept is dropped.
    in_valid = 1'b1;
    in_data  = 8'd11;
    @(posedge clk);
    #1;
    in_data = 8'd22;
    @(posedge clk);
    #1;
    in_data = 8'd33;
    abort   = 1'b1;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    drive_batch(5);
    drain(4);

    // Abort coinciding with an emit transfer.
    drive_batch(0);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_emit_in_ready",  {31'd0, in_ready},  32'd1);
    check("abort_emit_out_valid", {31'd0, out_valid}, 32'd0);
    sb_q.delete();
    drive_batch(2);
    drain(4);

    // Asynchronous reset in the middle of emission.
    drive_batch(0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("async_reset_out_data",  {24'd0, out_data},  32'd0);
    reset = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    drive_batch(1);
    drain(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
